// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: serialises 16-bit left/right samples into a Philips I2S stream.
// Bit clock and word clock are derived from clk_sys by a programmable divider.
// Data and word select change only on the BCK falling edge (1-BCK I2S delay).
module i2s_audio_tx #(
   parameter int BCK_DIV     = 7,
   parameter bit UNSIGNED_IN = 1'b0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] left,
   input  logic [15:0] right,
   output logic        sample_ack,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_data
);

   localparam int              DIV_W    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
   // Offset-binary samples become two's complement by flipping the MSB.
   localparam logic [15:0]     MSB_FLIP = UNSIGNED_IN ? 16'h8000 : 16'h0000;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             bck_q, bck_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic             lrck_q, lrck_d;
   logic [31:0]      sr_q, sr_d;
   logic             data_q, data_d;
   logic             ack_q, ack_d;
   logic             wrap_s;
   logic             fall_s;

   // Next-state logic: divider, bit clock, and frame shifter advanced on BCK fall.
   always_comb begin
      div_cnt_d = div_cnt_q;
      bck_d     = bck_q;
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      sr_d      = sr_q;
      data_d    = data_q;
      ack_d     = 1'b0;

      wrap_s = (div_cnt_q == DIV_LAST);
      fall_s = wrap_s & bck_q;

      if (wrap_s) begin
         div_cnt_d = '0;
         bck_d     = ~bck_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
         bck_d     = bck_q;
      end

      if (fall_s) begin
         bit_cnt_d = bit_cnt_q + 5'd1;
         lrck_d    = bit_cnt_d[4];
         // Old MSB goes out first; on a load this is the previous frame's R[0].
         data_d    = sr_q[31];
         if (bit_cnt_d == 5'd0) begin
            sr_d  = {left ^ MSB_FLIP, right ^ MSB_FLIP};
            ack_d = 1'b1;
         end else begin
            sr_d  = {sr_q[30:0], 1'b0};
            ack_d = 1'b0;
         end
      end else begin
         bit_cnt_d = bit_cnt_q;
         lrck_d    = lrck_q;
         data_d    = data_q;
         sr_d      = sr_q;
      end
   end

   // State registers with synchronous reset; bit_cnt starts at 31 so the first fall loads a frame.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div_cnt_q <= '0;
         bck_q     <= 1'b0;
         bit_cnt_q <= 5'd31;
         lrck_q    <= 1'b1;
         sr_q      <= 32'd0;
         data_q    <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bck_q     <= bck_d;
         bit_cnt_q <= bit_cnt_d;
         lrck_q    <= lrck_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
      end
   end

   assign sample_ack = ack_q;
   assign i2s_bck    = bck_q;
   assign i2s_lrck   = lrck_q;
   assign i2s_data   = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed testbench for i2s_audio_tx: three instances (BCK_DIV=2 signed,
// BCK_DIV=2 offset-binary, BCK_DIV=1) sharing one clock and reset.
module tb_i2s_audio_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] a_left, a_right, b_left, b_right, c_left, c_right;
   logic        a_ack, a_bck, a_lrck, a_data;
   logic        b_ack, b_bck, b_lrck, b_data;
   logic        c_ack, c_bck, c_lrck, c_data;

   int n_chk = 0;
   int n_err = 0;

   i2s_audio_tx #(.BCK_DIV(2), .UNSIGNED_IN(1'b0)) u_a (
      .clk_sys(clk), .reset(reset), .left(a_left), .right(a_right),
      .sample_ack(a_ack), .i2s_bck(a_bck), .i2s_lrck(a_lrck), .i2s_data(a_data));

   i2s_audio_tx #(.BCK_DIV(2), .UNSIGNED_IN(1'b1)) u_b (
      .clk_sys(clk), .reset(reset), .left(b_left), .right(b_right),
      .sample_ack(b_ack), .i2s_bck(b_bck), .i2s_lrck(b_lrck), .i2s_data(b_data));

   i2s_audio_tx #(.BCK_DIV(1), .UNSIGNED_IN(1'b0)) u_c (
      .clk_sys(clk), .reset(reset), .left(c_left), .right(c_right),
      .sample_ack(c_ack), .i2s_bck(c_bck), .i2s_lrck(c_lrck), .i2s_data(c_data));

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Edge-relationship monitor: lrck/data may only change when bck falls.
   logic rst_edge = 1'b1;
   logic pa_bck, pa_lrck, pa_data, pc_bck, pc_lrck, pc_data;
   bit   mon_en = 1'b0;
   int   viol_a = 0;
   int   viol_c = 0;

   // Records whether reset was sampled at the latest active edge.
   always @(posedge clk) rst_edge <= reset;

   // Flags any lrck/data change not coincident with a BCK fall.
   always @(negedge clk) begin
      if (mon_en && !rst_edge) begin
         if ((a_lrck !== pa_lrck || a_data !== pa_data) && !(pa_bck && !a_bck))
            viol_a <= viol_a + 1;
         if ((c_lrck !== pc_lrck || c_data !== pc_data) && !(pc_bck && !c_bck))
            viol_c <= viol_c + 1;
      end
      pa_bck <= a_bck; pa_lrck <= a_lrck; pa_data <= a_data;
      pc_bck <= c_bck; pc_lrck <= c_lrck; pc_data <= c_data;
   end

   // Waits for the next rising BCK edge of instance A and samples A/B outputs.
   task automatic next_rise(output logic ad, output logic al, output logic bd);
      logic prev;
      bit   found;
      prev  = a_bck;
      found = 1'b0;
      ad = 1'b0; al = 1'b0; bd = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (a_bck && !prev) begin
            found = 1'b1;
            ad = a_data; al = a_lrck; bd = b_data;
         end
         prev = a_bck;
      end
      if (!found) check("rise_timeout", 32'(found), 32'd1);
   endtask

   // Captures 32 consecutive bits (one frame); optionally changes inputs at bit index chg_at.
   task automatic get_frame(input bit chg, input int chg_at, input logic [15:0] nl,
                            input logic [15:0] nbr, output logic [31:0] aw,
                            output logic [31:0] lw, output logic [31:0] bw);
      logic d, l, bd;
      aw = 32'd0; lw = 32'd0; bw = 32'd0;
      for (int k = 0; k < 32; k++) begin
         next_rise(d, l, bd);
         aw = {aw[30:0], d};
         lw = {lw[30:0], l};
         bw = {bw[30:0], bd};
         if (chg && k == chg_at) begin
            a_left  = nl;
            b_right = nbr;
         end
      end
   endtask

   // Counts clk cycles until sample_ack of A (sel_c=0) or C (sel_c=1) is seen.
   task automatic count_to_ack(input bit sel_c, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         n++;
         if (sel_c ? c_ack : a_ack) found = 1'b1;
      end
      if (!found) check("ack_timeout", 32'(found), 32'd1);
   endtask

   localparam logic [31:0] LRCK_PAT = 32'h0001FFFE;

   initial begin
      int n;
      int t;
      logic d, l, bd, p;
      logic [31:0] aw, lw, bw;

      reset   = 1'b1;
      a_left  = 16'hA5C3; a_right = 16'h3C5A;
      b_left  = 16'h8000; b_right = 16'h8000;
      c_left  = 16'h1234; c_right = 16'h5678;
      repeat (3) @(negedge clk);

      check("rst_a_bck",  32'(a_bck),  32'd0);
      check("rst_a_lrck", 32'(a_lrck), 32'd1);
      check("rst_a_data", 32'(a_data), 32'd0);
      check("rst_a_ack",  32'(a_ack),  32'd0);
      check("rst_b_out",  {28'd0, b_ack, b_bck, b_lrck, b_data}, 32'h2);
      check("rst_c_out",  {29'd0, c_bck, c_lrck, c_ack}, 32'h2);

      mon_en = 1'b1;
      reset  = 1'b0;
      count_to_ack(1'b0, n);
      check("first_ack_lat", 32'(n), 32'd4);
      check("first_ack_lrck", 32'(a_lrck), 32'd0);
      check("first_ack_data", 32'(a_data), 32'd0);

      next_rise(d, l, bd);
      check("prev_r0_data", 32'(d), 32'd0);
      check("prev_r0_lrck", 32'(l), 32'd0);

      // Frame 1: held A5C3/3C5A
      get_frame(1'b0, 0, 16'h0, 16'h0, aw, lw, bw);
      check("f1_data", aw, 32'hA5C33C5A);
      check("f1_lrck", lw, LRCK_PAT);
      check("f1_unsigned", bw, 32'h00000000);

      // Frame 2: inputs change mid-frame, frame already loaded
      get_frame(1'b1, 4, 16'h0001, 16'h0001, aw, lw, bw);
      check("f2_data", aw, 32'hA5C33C5A);
      check("f2_lrck", lw, LRCK_PAT);
      check("f2_unsigned", bw, 32'h00000000);

      // Frame 3: carries 0001; left changes to 8000 mid-frame
      get_frame(1'b1, 8, 16'h8000, 16'h0001, aw, lw, bw);
      check("f3_data", aw, 32'h00013C5A);
      check("f3_unsigned", bw, 32'h00008001);

      // Frame 4: picks up 8000
      get_frame(1'b0, 0, 16'h0, 16'h0, aw, lw, bw);
      check("f4_data", aw, 32'h80003C5A);
      check("f4_lrck", lw, LRCK_PAT);

      count_to_ack(1'b0, n);
      count_to_ack(1'b0, n);
      check("ack_period_a", 32'(n), 32'd128);

      // Reset mid-frame around bit_cnt 20
      for (int k = 0; k < 20; k++) next_rise(d, l, bd);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_bck",  32'(a_bck),  32'd0);
      check("mid_rst_lrck", 32'(a_lrck), 32'd1);
      check("mid_rst_data", 32'(a_data), 32'd0);
      check("mid_rst_ack",  32'(a_ack),  32'd0);
      reset = 1'b0;
      count_to_ack(1'b0, n);
      check("mid_rst_ack_lat", 32'(n), 32'd4);

      // BCK_DIV=1 instance
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      count_to_ack(1'b1, n);
      check("c_first_ack_lat", 32'(n), 32'd2);
      check("c_first_lrck", 32'(c_lrck), 32'd0);
      count_to_ack(1'b1, n);
      check("c_ack_period", 32'(n), 32'd64);
      p = c_bck;
      t = 0;
      repeat (8) begin
         @(negedge clk);
         if (c_bck !== p) t++;
         p = c_bck;
      end
      check("c_bck_toggles", 32'(t), 32'd8);

      repeat (200) @(negedge clk);
      check("edge_rel_a", 32'(viol_a), 32'd0);
      check("edge_rel_c", 32'(viol_c), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
